// File: rtl/btn_event_encoder.sv
// Conditions two raw active-low pushbuttons into a single committed 2-bit button code:
// synchronise, debounce, classify one press per gesture, hold until full release.
module btn_event_encoder #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CHORD_CYCLES    = 5000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn_n,
  output logic [1:0] event_code,
  output logic       press_evt,
  output logic       release_evt,
  output logic [7:0] evt_count
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CH_LAST = CNT_W'(CHORD_CYCLES - 1);

  // Handshake: press_evt / release_evt are single-cycle strobes with no back-pressure;
  // event_code is valid every cycle and only changes in a strobe cycle.

  typedef enum logic [1:0] {
    IDLE,
    CHORD_WAIT,
    HELD,
    RELEASE
  } state_t;

  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       db;
  logic [CNT_W-1:0] db_cnt [2];

  state_t           state;
  state_t           state_nx;
  logic [1:0]       cap_code;
  logic [1:0]       cap_nx;
  logic [CNT_W-1:0] chord_cnt;
  logic [CNT_W-1:0] chord_nx;
  logic [1:0]       code_nx;
  logic             press_nx;
  logic             release_nx;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  // A bit is accepted only after DEBOUNCE_CYCLES consecutive samples disagree with db.
  always_ff @(posedge clk) begin
    if (!reset) begin
      db <= 2'b11;
      for (int b = 0; b < 2; b++) db_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (sync2[b] != db[b]) begin
          if (db_cnt[b] == DB_LAST) begin
            db[b]     <= sync2[b];
            db_cnt[b] <= '0;
          end else begin
            db_cnt[b] <= db_cnt[b] + 1'b1;
          end
        end else begin
          db_cnt[b] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cap_code    <= 2'b11;
      chord_cnt   <= '0;
      event_code  <= 2'b11;
      press_evt   <= 1'b0;
      release_evt <= 1'b0;
      evt_count   <= 8'd0;
    end else begin
      state       <= state_nx;
      cap_code    <= cap_nx;
      chord_cnt   <= chord_nx;
      event_code  <= code_nx;
      press_evt   <= press_nx;
      release_evt <= release_nx;
      if (press_nx) evt_count <= evt_count + 8'd1;
    end
  end

  always_comb begin
    state_nx   = state;
    cap_nx     = cap_code;
    chord_nx   = chord_cnt;
    code_nx    = event_code;
    press_nx   = 1'b0;
    release_nx = 1'b0;
    case (state)
      IDLE: begin
        if (db == 2'b00) begin
          code_nx  = 2'b00;
          press_nx = 1'b1;
          state_nx = HELD;
        end else if (db != 2'b11) begin
          cap_nx   = db;
          chord_nx = '0;
          state_nx = CHORD_WAIT;
        end
      end
      CHORD_WAIT: begin
        chord_nx = chord_cnt + 1'b1;
        // Chord beats tap beats timeout when they coincide.
        if (db == 2'b00) begin
          code_nx  = 2'b00;
          press_nx = 1'b1;
          state_nx = HELD;
        end else if (db == 2'b11) begin
          code_nx  = cap_code;
          press_nx = 1'b1;
          state_nx = RELEASE;
        end else if (chord_cnt == CH_LAST) begin
          code_nx  = cap_code;
          press_nx = 1'b1;
          state_nx = HELD;
        end
      end
      HELD: begin
        if (db == 2'b11) begin
          code_nx    = 2'b11;
          release_nx = 1'b1;
          state_nx   = IDLE;
        end
      end
      RELEASE: begin
        code_nx    = 2'b11;
        release_nx = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_btn_event_encoder.sv
// Randomised and directed bench for btn_event_encoder: a gesture-level reference model
// predicts press/release strobes into a queue that an independent monitor drains.
module tb_btn_event_encoder;

  localparam int D = 4;
  localparam int C = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] btn_n;
  logic [1:0] event_code;
  logic       press_evt;
  logic       release_evt;
  logic [7:0] evt_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // {edge cycle[15:0], is_press, code[1:0], count[7:0]}
  logic [26:0] exp_q[$];

  always #5 clk = ~clk;

  btn_event_encoder #(
    .DEBOUNCE_CYCLES(D),
    .CHORD_CYCLES   (C),
    .CNT_W          (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_n      (btn_n),
    .event_code (event_code),
    .press_evt  (press_evt),
    .release_evt(release_evt),
    .evt_count  (evt_count)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // ---------------- reference model (evaluated at each rising edge) ----------------
  logic [1:0] pipe_q[$];
  logic [1:0] s_hist[$];
  int         last_chg [2];
  logic [1:0] m_db;
  logic [1:0] m_code;
  logic [7:0] m_count;
  bit         g_active, g_committed, g_tap;
  logic [1:0] g_first;
  int         g_t0;

  task automatic model_press(input logic [1:0] code);
    m_code  = code;
    m_count = m_count + 8'd1;
    exp_q.push_back({cyc[15:0], 1'b1, code, m_count});
  endtask

  task automatic model_release();
    m_code = 2'b11;
    exp_q.push_back({cyc[15:0], 1'b0, 2'b11, m_count});
  endtask

  always @(posedge clk) begin
    logic [1:0] s;
    logic [1:0] new_db;
    bit         stable;
    cyc++;
    if (!reset) begin
      pipe_q = '{2'b11, 2'b11};
      s_hist.delete();
      last_chg = '{0, 0};
      m_db = 2'b11; m_code = 2'b11; m_count = 8'd0;
      g_active = 0; g_committed = 0; g_tap = 0; g_first = 2'b11; g_t0 = 0;
      exp_q.delete();
    end else begin
      // Gesture classification acts on the debounced level from before this edge.
      if (g_tap) begin
        g_tap = 0;
        model_release();
      end else if (!g_active) begin
        if (m_db == 2'b00) begin
          g_active = 1; g_committed = 1; model_press(2'b00);
        end else if (m_db != 2'b11) begin
          g_active = 1; g_committed = 0; g_first = m_db; g_t0 = cyc;
        end
      end else if (!g_committed) begin
        if (m_db == 2'b00) begin
          g_committed = 1; model_press(2'b00);
        end else if (m_db == 2'b11) begin
          g_active = 0; g_tap = 1; model_press(g_first);
        end else if (cyc - g_t0 == C) begin
          g_committed = 1; model_press(g_first);
        end
      end else if (m_db == 2'b11) begin
        g_active = 0; g_committed = 0; model_release();
      end
      // Two-stage synchroniser delay, then "D identical fresh samples" acceptance.
      s = pipe_q.pop_front();
      pipe_q.push_back(btn_n);
      s_hist.push_back(s);
      new_db = m_db;
      for (int b = 0; b < 2; b++) begin
        if (s[b] != m_db[b] && (s_hist.size() - last_chg[b]) >= D) begin
          stable = 1;
          for (int k = 0; k < D; k++)
            if (s_hist[s_hist.size() - 1 - k][b] != s[b]) stable = 0;
          if (stable) begin
            new_db[b]   = s[b];
            last_chg[b] = s_hist.size();
          end
        end
      end
      m_db = new_db;
    end
  end

  // ---------------- monitor ----------------
  int         obs_press = 0;
  int         obs_release = 0;
  logic [1:0] last_press_code = 2'b11;
  int         last_press_cyc = 0;
  int         last_rel_cyc = 0;

  always @(negedge clk) begin
    logic [26:0] e;
    if (press_evt && release_evt) check("both_pulses", 1, 0);
    if (press_evt || release_evt) begin
      if (press_evt) begin
        obs_press++; last_press_code = event_code; last_press_cyc = cyc;
      end else begin
        obs_release++; last_rel_cyc = cyc;
      end
      if (exp_q.size() == 0) begin
        check("unexpected_evt", {cyc[15:0], press_evt, event_code, evt_count}, 0);
      end else begin
        e = exp_q.pop_front();
        check("evt", {5'd0, cyc[15:0], press_evt, event_code, evt_count}, {5'd0, e});
      end
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("missing_evt", 0, {5'd0, e});
    end
    check("event_code", {30'd0, event_code}, {30'd0, m_code});
    check("evt_count", {24'd0, evt_count}, {24'd0, m_count});
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [1:0] v, input int n);
    @(negedge clk);
    btn_n = v;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset(input int n);
    @(negedge clk);
    reset = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_evt(input bit want_press, input int limit, output int at);
    bit found = 0;
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (want_press ? press_evt : release_evt) begin
        found = 1; at = cyc; break;
      end
    end
    if (!found) check(want_press ? "press_timeout" : "release_timeout", 0, 1);
  endtask

  task automatic tap();
    drive(2'b10, 6);
    drive(2'b11, 8);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0, at, p0, r0;
    reset = 1'b0;
    btn_n = 2'b11;
    idle(3);
    reset = 1'b1;
    check("rst_code", {30'd0, event_code}, 32'h3);
    check("rst_press", {31'd0, press_evt}, 0);
    check("rst_release", {31'd0, release_evt}, 0);
    check("rst_count", {24'd0, evt_count}, 0);
    idle(20);
    check("idle_code", {30'd0, event_code}, 32'h3);

    // Bounce shorter than the debounce window is ignored.
    p0 = obs_press;
    for (int i = 0; i < 10; i++) drive((i % 2 == 0) ? 2'b10 : 2'b11, 2);
    drive(2'b11, 20);
    check("bounce_no_press", obs_press - p0, 0);

    // Single button: press latency and release latency.
    @(negedge clk);
    btn_n = 2'b10; t0 = cyc;
    wait_evt(1, 40, at);
    check("single_latency", at - t0, 15);
    check("single_code", {30'd0, event_code}, 32'h2);
    check("single_count", {24'd0, evt_count}, 1);
    idle(15);
    btn_n = 2'b11; t0 = cyc;
    wait_evt(0, 40, at);
    check("release_latency", at - t0, 7);
    check("release_code", {30'd0, event_code}, 32'h3);
    idle(10);

    // Staggered chord, staggered release.
    p0 = obs_press; r0 = obs_release;
    drive(2'b10, 3);
    drive(2'b00, 20);
    drive(2'b01, 10);
    check("chord_no_early_release", obs_release - r0, 0);
    drive(2'b11, 20);
    check("chord_one_press", obs_press - p0, 1);
    check("chord_one_release", obs_release - r0, 1);
    check("chord_code", {30'd0, last_press_code}, 0);

    // Tap.
    drive(2'b01, 8);
    drive(2'b11, 20);
    check("tap_code", {30'd0, last_press_code}, 32'h1);
    check("tap_release_gap", last_rel_cyc - last_press_cyc, 1);

    // Reset while held: no release strobe, held button re-detected afterwards.
    drive(2'b10, 20);
    r0 = obs_release; p0 = obs_press;
    pulse_reset(1);
    check("midrst_code", {30'd0, event_code}, 32'h3);
    check("midrst_count", {24'd0, evt_count}, 0);
    idle(25);
    check("midrst_no_release", obs_release - r0, 0);
    check("held_repress", obs_press - p0, 1);
    drive(2'b11, 20);

    // Counter wrap.
    pulse_reset(2);
    p0 = obs_press;
    for (int i = 0; i < 256; i++) tap();
    idle(10);
    check("wrap_presses", obs_press - p0, 256);
    check("wrap_count", {24'd0, evt_count}, 0);

    // Random gestures with occasional resets.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 39) == 0) pulse_reset($urandom_range(1, 3));
      drive(2'($urandom_range(0, 3)), $urandom_range(1, 20));
    end
    drive(2'b11, 40);
    check("drain_code", {30'd0, event_code}, 32'h3);
    check("drain_queue", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
